// File: rtl/pipe_pkg.sv
// Shared widths, control-bit positions and the packed beat layout for the
// datapath pipeline stage registers.
package pipe_pkg;

  localparam int DEF_CTRL_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0] ctrl;
    logic [DEF_DATA_W-1:0] data_a;
    logic [DEF_DATA_W-1:0] data_b;
    logic [DEF_RD_W-1:0]   rd;
  } beat_t;

endpackage

// File: rtl/pipe_beat_reg.sv
// One beat entry: a valid bit plus a flat payload, with reset, valid-only
// clear (flush) and load enable, in that priority order.
module pipe_beat_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         valid_d_i,
  input  logic [W-1:0] data_d_i,
  output logic         valid_q_o,
  output logic [W-1:0] data_q_o
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Clear leaves the payload stale on purpose; only reset zeroes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (clr_i) begin
      valid_r <= 1'b0;
    end else if (en_i) begin
      valid_r <= valid_d_i;
      data_r  <= data_d_i;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid_q_o = valid_r;
  assign data_q_o  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Datapath pipeline stage register with valid/ready handshake, stall hold,
// flush-to-bubble and an optional skid entry that registers ready_o.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W,
  parameter int SKID   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [RD_W-1:0]   rd_o
);

  localparam int BEAT_W = CTRL_W + DATA_W + DATA_W + RD_W;

  logic [BEAT_W-1:0] in_beat_s;
  logic [BEAT_W-1:0] out_beat_s;
  logic [BEAT_W-1:0] out_d_s;
  logic              out_valid_s;
  logic              out_en_s;
  logic              out_vd_s;
  logic              ready_s;
  logic [CTRL_W-1:0] ctrl_q_s;

  assign in_beat_s = {ctrl_i, data_a_i, data_b_i, rd_i};

  generate
    if (SKID == 0) begin : g_noskid
      // An empty stage loads even under stall: there is nothing to hold.
      always_comb begin
        ready_s  = (~out_valid_s | (ready_i & ~stall_i)) & ~flush_i;
        out_en_s = ready_s;
        out_vd_s = valid_i;
        out_d_s  = in_beat_s;
      end
    end else begin : g_skid
      logic              skid_valid_s;
      logic              skid_en_s;
      logic              skid_vd_s;
      logic              adv_s;
      logic              in_fire_s;
      logic [BEAT_W-1:0] skid_beat_s;

      // Output advances when empty or draining; the skid refills it first.
      always_comb begin
        ready_s   = ~skid_valid_s;
        in_fire_s = valid_i & ready_s;
        adv_s     = ~out_valid_s | (ready_i & ~stall_i);
        out_en_s  = adv_s;
        out_vd_s  = 1'b0;
        out_d_s   = in_beat_s;
        skid_en_s = 1'b0;
        skid_vd_s = 1'b0;
        if (adv_s) begin
          if (skid_valid_s) begin
            out_vd_s  = 1'b1;
            out_d_s   = skid_beat_s;
            skid_en_s = 1'b1;
            skid_vd_s = 1'b0;
          end else begin
            out_vd_s = in_fire_s;
          end
        end else begin
          if (in_fire_s) begin
            skid_en_s = 1'b1;
            skid_vd_s = 1'b1;
          end else begin
            skid_en_s = 1'b0;
          end
        end
      end

      pipe_beat_reg #(.W(BEAT_W)) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (flush_i),
        .en_i      (skid_en_s),
        .valid_d_i (skid_vd_s),
        .data_d_i  (in_beat_s),
        .valid_q_o (skid_valid_s),
        .data_q_o  (skid_beat_s)
      );
    end
  endgenerate

  pipe_beat_reg #(.W(BEAT_W)) u_out (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .en_i      (out_en_s),
    .valid_d_i (out_vd_s),
    .data_d_i  (out_d_s),
    .valid_q_o (out_valid_s),
    .data_q_o  (out_beat_s)
  );

  assign {ctrl_q_s, data_a_o, data_b_o, rd_o} = out_beat_s;
  assign ctrl_o  = out_valid_s ? ctrl_q_s : {CTRL_W{1'b0}};
  assign valid_o = out_valid_s;
  assign ready_o = ready_s;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table vectors on the SKID=0 instance, directed
// skid sequence, and a random run with per-instance scoreboards.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst, vld, rdy, stl, fl;
  logic [3:0]  ctrl;
  logic [31:0] da, db;
  logic [4:0]  rd;

  logic        rdy0, v0, rdy1, v1;
  logic [3:0]  c0, c1;
  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  r0, r1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc1  = 0;
  beat_t q0[$];
  beat_t q1[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(rdy0), .ctrl_i(ctrl),
    .data_a_i(da), .data_b_i(db), .rd_i(rd), .stall_i(stl), .flush_i(fl),
    .valid_o(v0), .ready_i(rdy), .ctrl_o(c0), .data_a_o(a0), .data_b_o(b0), .rd_o(r0));

  pipe_stage_reg #(.SKID(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(vld), .ready_o(rdy1), .ctrl_i(ctrl),
    .data_a_i(da), .data_b_i(db), .rd_i(rd), .stall_i(stl), .flush_i(fl),
    .valid_o(v1), .ready_i(rdy), .ctrl_o(c1), .data_a_o(a1), .data_b_o(b1), .rd_o(r1));

  typedef struct {
    logic rst, vld, rdy, stl, fl;
    logic [3:0] ctrl; logic [31:0] da; logic [4:0] rd;
    logic e_v; logic [3:0] e_c; logic [31:0] e_da; logic [4:0] e_rd; logic e_rdy; logic chk;
  } vec_t;
  vec_t tbl[13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_port(input int d, input logic vo, input logic ro, input beat_t ob);
    beat_t inb;
    beat_t e;
    int    sz;
    inb = '{ctrl: ctrl, data_a: da, data_b: db, rd: rd};
    sz  = (d == 0) ? q0.size() : q1.size();
    if (!vo) check($sformatf("ctrl_gate%0d", d), {124'd0, ob.ctrl}, 128'd0);
    if (rst || fl) begin
      if (d == 0) q0.delete(); else q1.delete();
    end else begin
      if (vo && rdy && !stl) begin
        if (sz == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb%0d_extra: got beat %0h expected none", d, ob);
        end else begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          check($sformatf("sb%0d_beat", d), {55'd0, ob}, {55'd0, e});
        end
      end
      if (vld && ro) begin
        if (d == 0) q0.push_back(inb);
        else begin q1.push_back(inb); acc1++; end
      end
    end
  endtask

  // One clock: scoreboard at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    sb_port(0, v0, rdy0, '{ctrl: c0, data_a: a0, data_b: b0, rd: r0});
    sb_port(1, v1, rdy1, '{ctrl: c1, data_a: a1, data_b: b1, rd: r1});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic rr, input logic s, input logic f,
                       input logic [3:0] c, input logic [31:0] a, input logic [4:0] d);
    rst = r; vld = v; rdy = rr; stl = s; fl = f; ctrl = c; da = a; db = ~a; rd = d;
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{1,0,0,0,0, 4'h0, 32'h0,        5'd0,  0,4'h0,32'h0,        5'd0,  1,1};
    tbl[1]  = '{0,1,0,0,0, 4'h1, 32'h1234,     5'd3,  1,4'h1,32'h1234,     5'd3,  0,1};
    tbl[2]  = '{1,0,0,0,0, 4'h0, 32'h0,        5'd0,  0,4'h0,32'h0,        5'd0,  1,1};
    tbl[3]  = '{0,1,0,0,0, 4'h5, 32'hDEADBEEF, 5'd7,  1,4'h5,32'hDEADBEEF, 5'd7,  0,1};
    tbl[4]  = '{0,1,1,1,0, 4'h3, 32'h11,       5'd2,  1,4'h5,32'hDEADBEEF, 5'd7,  0,1};
    tbl[5]  = '{0,1,1,1,0, 4'h3, 32'h11,       5'd2,  1,4'h5,32'hDEADBEEF, 5'd7,  0,1};
    tbl[6]  = '{0,1,1,1,0, 4'h3, 32'h11,       5'd2,  1,4'h5,32'hDEADBEEF, 5'd7,  0,1};
    tbl[7]  = '{0,1,1,1,1, 4'h2, 32'h22,       5'd4,  0,4'h0,32'h0,        5'd0,  0,0};
    tbl[8]  = '{0,0,1,0,0, 4'h0, 32'h0,        5'd0,  0,4'h0,32'h0,        5'd0,  1,0};
    tbl[9]  = '{0,1,1,0,0, 4'h8, 32'h33,       5'd9,  1,4'h8,32'h33,       5'd9,  1,1};
    tbl[10] = '{0,0,1,0,0, 4'h0, 32'h0,        5'd0,  0,4'h0,32'h0,        5'd0,  1,0};
    tbl[11] = '{0,1,0,0,0, 4'hF, 32'h44,       5'd31, 1,4'hF,32'h44,       5'd31, 0,1};
    tbl[12] = '{0,1,1,0,0, 4'h1, 32'h55,       5'd1,  1,4'h1,32'h55,       5'd1,  1,1};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].rdy, tbl[i].stl, tbl[i].fl,
            tbl[i].ctrl, tbl[i].da, tbl[i].rd);
      step();
      check($sformatf("v%0d_valid", i), {127'd0, v0}, {127'd0, tbl[i].e_v});
      check($sformatf("v%0d_ctrl", i), {124'd0, c0}, {124'd0, tbl[i].e_c});
      check($sformatf("v%0d_ready", i), {127'd0, rdy0}, {127'd0, tbl[i].e_rdy});
      if (tbl[i].chk) begin
        check($sformatf("v%0d_data_a", i), {96'd0, a0}, {96'd0, tbl[i].e_da});
        check($sformatf("v%0d_rd", i), {123'd0, r0}, {123'd0, tbl[i].e_rd});
      end
    end

    // Back-to-back beats through the single-register stage.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h1, k, k[4:0]);
      step();
      check($sformatf("b2b%0d_valid", k), {127'd0, v0}, 128'd1);
      check($sformatf("b2b%0d_data_a", k), {96'd0, a0}, k);
      check($sformatf("b2b%0d_ready", k), {127'd0, rdy0}, 128'd1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0);
    step();

    // Skid absorb on the SKID=1 instance.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'd1, 5'd1);
    step();
    check("skid_s1_data_a", {96'd0, a1}, 128'd1);
    check("skid_s1_ready", {127'd0, rdy1}, 128'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 32'd2, 5'd2);
    step();
    check("skid_s2_data_a", {96'd0, a1}, 128'd1);
    check("skid_s2_ready", {127'd0, rdy1}, 128'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0);
    step();
    check("skid_s3_valid", {127'd0, v1}, 128'd1);
    check("skid_s3_data_a", {96'd0, a1}, 128'd2);
    check("skid_s3_ready", {127'd0, rdy1}, 128'd1);
    step();
    check("skid_s4_valid", {127'd0, v1}, 128'd0);
    check("skid_s4_ctrl", {124'd0, c1}, 128'd0);

    // Random traffic; scoreboards track both instances.
    acc1 = 0;
    cyc  = 0;
    while (acc1 < 1000 && cyc < 20000) begin
      drive(1'b0, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 5) == 0,
            ($urandom % 97) == 0, 4'($urandom), $urandom, 5'($urandom));
      step();
      cyc++;
    end
    if (acc1 < 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL rand_budget: got %0d beats expected 1000", acc1);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0);
    repeat (6) step();
    check("drain_q0", q0.size(), 128'd0);
    check("drain_q1", q1.size(), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
